// File: rtl/morse_stream_decoder_if.sv
// Keyed-line input and decoded-character output bundle for the Morse decoder.
// master drives the key line and observes characters; slave is the decoder side.
interface morse_stream_decoder_if;
    logic       key_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       err;

    modport master (output key_in, input out_data, input out_valid, input err);
    modport slave  (input key_in, output out_data, output out_valid, output err);
endinterface

// File: rtl/morse_stream_decoder.sv
// Timing-aware Morse receiver: classifies marks, buffers up to 5 symbols, emits ASCII on gaps.
// Characters strobe one cycle after the gap threshold cycle; no backpressure, the sink must keep up.
module morse_stream_decoder #(
    parameter int unsigned UNIT_CYCLES      = 10,
    parameter int unsigned MIN_MARK         = 3,
    parameter int unsigned DASH_UNITS       = 2,
    parameter int unsigned LETTER_GAP_UNITS = 3,
    parameter int unsigned WORD_GAP_UNITS   = 7,
    parameter int unsigned CNT_W            = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    morse_stream_decoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_e;

    // Gap thresholds are compared one count early so the strobe lands exactly on the threshold.
    localparam logic [CNT_W-1:0] MIN_T    = CNT_W'(MIN_MARK);
    localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_T = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_T   = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sym_len_q, sym_len_d;
    logic [4:0]         sym_pat_q, sym_pat_d;
    logic               ovf_q, ovf_d;
    logic               word_pend_q, word_pend_d;
    logic               key_q, key_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    logic               rise, fall, at_letter, at_word, letter_hit, word_hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic [7:0]         lut_char;

    assign rise       = bus.key_in & ~key_q;
    assign fall       = ~bus.key_in & key_q;
    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign at_letter  = (state_q == SPACE) && (cnt_q == LETTER_T);
    assign at_word    = (state_q == SPACE) && (cnt_q == WORD_T);
    assign letter_hit = at_letter && (sym_len_q != 3'd0);
    assign word_hit   = at_word && word_pend_q;

    // Code is {length, right-justified pattern}; dot = 0, dash = 1. Zero means not a valid code.
    function automatic logic [7:0] morse_lut(input logic [7:0] code);
        case (code)
            8'b010_00001: morse_lut = 8'h41; 8'b100_01000: morse_lut = 8'h42;
            8'b100_01010: morse_lut = 8'h43; 8'b011_00100: morse_lut = 8'h44;
            8'b001_00000: morse_lut = 8'h45; 8'b100_00010: morse_lut = 8'h46;
            8'b011_00110: morse_lut = 8'h47; 8'b100_00000: morse_lut = 8'h48;
            8'b010_00000: morse_lut = 8'h49; 8'b100_00111: morse_lut = 8'h4A;
            8'b011_00101: morse_lut = 8'h4B; 8'b100_00100: morse_lut = 8'h4C;
            8'b010_00011: morse_lut = 8'h4D; 8'b010_00010: morse_lut = 8'h4E;
            8'b011_00111: morse_lut = 8'h4F; 8'b100_00110: morse_lut = 8'h50;
            8'b100_01101: morse_lut = 8'h51; 8'b011_00010: morse_lut = 8'h52;
            8'b011_00000: morse_lut = 8'h53; 8'b001_00001: morse_lut = 8'h54;
            8'b011_00001: morse_lut = 8'h55; 8'b100_00001: morse_lut = 8'h56;
            8'b011_00011: morse_lut = 8'h57; 8'b100_01001: morse_lut = 8'h58;
            8'b100_01011: morse_lut = 8'h59; 8'b100_01100: morse_lut = 8'h5A;
            8'b101_11111: morse_lut = 8'h30; 8'b101_01111: morse_lut = 8'h31;
            8'b101_00111: morse_lut = 8'h32; 8'b101_00011: morse_lut = 8'h33;
            8'b101_00001: morse_lut = 8'h34; 8'b101_00000: morse_lut = 8'h35;
            8'b101_10000: morse_lut = 8'h36; 8'b101_11000: morse_lut = 8'h37;
            8'b101_11100: morse_lut = 8'h38; 8'b101_11110: morse_lut = 8'h39;
            default:      morse_lut = 8'h00;
        endcase
    endfunction

    assign lut_char = morse_lut({sym_len_q, sym_pat_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sym_len_q   <= '0;
            sym_pat_q   <= '0;
            ovf_q       <= 1'b0;
            word_pend_q <= 1'b0;
            key_q       <= 1'b1;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sym_len_q   <= sym_len_d;
            sym_pat_q   <= sym_pat_d;
            ovf_q       <= ovf_d;
            word_pend_q <= word_pend_d;
            key_q       <= key_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sym_len_d   = sym_len_q;
        sym_pat_d   = sym_pat_q;
        ovf_d       = ovf_q;
        word_pend_d = word_pend_q;
        key_d       = bus.key_in;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end
            end
            MARK: begin
                if (bus.key_in) begin
                    cnt_d = cnt_inc;
                end else if (fall) begin
                    cnt_d = '0;
                    if (cnt_q < MIN_T) begin
                        // A glitch with nothing buffered and no word pending came from IDLE.
                        state_d = (sym_len_q == 3'd0 && !word_pend_q) ? IDLE : SPACE;
                    end else begin
                        state_d = SPACE;
                        if (sym_len_q < 3'd5) begin
                            sym_pat_d = {sym_pat_q[3:0], (cnt_q >= DASH_T)};
                            sym_len_d = sym_len_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            SPACE: begin
                if (letter_hit) begin
                    sym_len_d   = '0;
                    sym_pat_d   = '0;
                    ovf_d       = 1'b0;
                    word_pend_d = 1'b1;
                end
                if (at_word) begin
                    word_pend_d = 1'b0;
                    state_d     = rise ? MARK : IDLE;
                    cnt_d       = rise ? CNT_W'(1) : '0;
                end else if (rise) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        if (letter_hit) begin
            out_valid_d = 1'b1;
            if (ovf_q || lut_char == 8'h00) begin
                out_data_d = 8'h3F;
                err_d      = 1'b1;
            end else begin
                out_data_d = lut_char;
            end
        end else if (word_hit) begin
            out_valid_d = 1'b1;
            out_data_d  = 8'h20;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Bench for morse_stream_decoder: table of mark sequences plus hand-built timing corner cases.
module tb_morse_stream_decoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    morse_stream_decoder_if bus();

    morse_stream_decoder #(
        .UNIT_CYCLES(10), .MIN_MARK(3), .DASH_UNITS(2),
        .LETTER_GAP_UNITS(3), .WORD_GAP_UNITS(7), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         due;
    } exp_t;

    typedef struct {
        int         nm;
        int         ml[6];
        logic [7:0] ch;
        logic       er;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[15];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge and matched against the scoreboard.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid === 1'b1) begin
            check("back_to_back_valid", 32'(prev_vld), 32'd0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got out_data=%02h want no strobe (cycle %0d)",
                         bus.out_data, cyc);
            end else begin
                x = sbq.pop_front();
                check("out_data", 32'(bus.out_data), 32'(x.d));
                check("err", 32'(bus.err), 32'(x.e));
                check("strobe_cycle", 32'(cyc), 32'(x.due));
            end
        end
        prev_vld = bus.out_valid;
    endtask

    task automatic drive(input logic k, input int n);
        bus.key_in = k;
        repeat (n) tick();
    endtask

    task automatic push_exp(input logic [7:0] d, input logic e, input int due);
        exp_t x;
        x.d = d; x.e = e; x.due = due;
        sbq.push_back(x);
    endtask

    // Character 31 cycles after the final fall, word space 71 cycles after it.
    task automatic push_char(input logic [7:0] ch, input logic er, input int fall);
        if (ch != 8'h00) begin
            push_exp(ch, er, fall + 31);
            push_exp(8'h20, 1'b0, fall + 71);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check({name, "_pending"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_out_data"}, 32'(bus.out_data), 32'h00);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic set_vec(input int i, input int nm, input int m0, input int m1, input int m2,
                           input int m3, input int m4, input int m5,
                           input logic [7:0] ch, input logic er);
        vt[i].nm = nm;
        vt[i].ml[0] = m0; vt[i].ml[1] = m1; vt[i].ml[2] = m2;
        vt[i].ml[3] = m3; vt[i].ml[4] = m4; vt[i].ml[5] = m5;
        vt[i].ch = ch;
        vt[i].er = er;
    endtask

    task automatic play(input int idx);
        int f;
        for (int i = 0; i < vt[idx].nm; i++) begin
            drive(1'b1, vt[idx].ml[i]);
            if (i < vt[idx].nm - 1) drive(1'b0, 10);
        end
        f = cyc;
        push_char(vt[idx].ch, vt[idx].er, f);
        drive(1'b0, 100);
        drain($sformatf("vec%0d", idx));
        if (vt[idx].ch != 8'h00)
            check($sformatf("vec%0d_hold", idx), 32'(bus.out_data), 32'h20);
    endtask

    initial begin
        int f;
        int f2;
        set_vec(0,  2, 10, 30,  0,  0,  0,  0, 8'h41, 1'b0);
        set_vec(1,  5, 30, 30, 30, 30, 30,  0, 8'h30, 1'b0);
        set_vec(2,  1, 19,  0,  0,  0,  0,  0, 8'h45, 1'b0);
        set_vec(3,  1, 20,  0,  0,  0,  0,  0, 8'h54, 1'b0);
        set_vec(4,  2, 19, 20,  0,  0,  0,  0, 8'h41, 1'b0);
        set_vec(5,  2, 20, 19,  0,  0,  0,  0, 8'h4E, 1'b0);
        set_vec(6,  6, 10, 10, 10, 10, 10, 10, 8'h3F, 1'b1);
        set_vec(7,  4, 10, 10, 30, 30,  0,  0, 8'h3F, 1'b1);
        set_vec(8,  3, 10, 10, 10,  0,  0,  0, 8'h53, 1'b0);
        set_vec(9,  4, 30, 30, 10, 30,  0,  0, 8'h51, 1'b0);
        set_vec(10, 5, 30, 30, 30, 30, 10,  0, 8'h39, 1'b0);
        set_vec(11, 3, 30, 10, 30,  0,  0,  0, 8'h4B, 1'b0);
        set_vec(12, 5, 10, 10, 10, 30, 30,  0, 8'h33, 1'b0);
        set_vec(13, 1,  3,  0,  0,  0,  0,  0, 8'h45, 1'b0);
        set_vec(14, 1,  2,  0,  0,  0,  0,  0, 8'h00, 1'b0);

        // Key held high across reset must never start a mark.
        reset = 1'b1;
        bus.key_in = 1'b1;
        repeat (3) tick();
        check_reset_outs("reset");
        reset = 1'b0;
        drive(1'b1, 100);
        drive(1'b0, 100);
        check("held_key_out_data", 32'(bus.out_data), 32'h00);
        drain("held_key");

        for (int v = 0; v < 15; v++) play(v);

        drive(1'b0, 200);
        check("idle_hold", 32'(bus.out_data), 32'h20);

        // Glitch inside the letter gap is discarded and restarts the gap count.
        drive(1'b1, 10);
        drive(1'b0, 5);
        drive(1'b1, 2);
        f = cyc;
        push_char(8'h45, 1'b0, f);
        drive(1'b0, 100);
        drain("gap_glitch");

        // Rise on the letter-threshold cycle: E still emitted, new mark starts empty.
        drive(1'b1, 10);
        f = cyc;
        push_exp(8'h45, 1'b0, f + 31);
        drive(1'b0, 30);
        drive(1'b1, 30);
        f2 = cyc;
        push_char(8'h54, 1'b0, f2);
        drive(1'b0, 100);
        drain("letter_rise");

        // Rise on the word-threshold cycle: space still emitted, new mark starts.
        drive(1'b1, 10);
        f = cyc;
        push_char(8'h45, 1'b0, f);
        drive(1'b0, 70);
        drive(1'b1, 30);
        f2 = cyc;
        push_char(8'h54, 1'b0, f2);
        drive(1'b0, 100);
        drain("word_rise");

        // Reset during the second mark of 'A' discards it silently.
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 15);
        reset = 1'b1;
        tick();
        tick();
        check_reset_outs("mid_reset");
        reset = 1'b0;
        drive(1'b1, 15);
        drive(1'b0, 100);
        check("post_reset_out_data", 32'(bus.out_data), 32'h00);
        drain("mid_reset");
        drive(1'b1, 30);
        f = cyc;
        push_char(8'h54, 1'b0, f);
        drive(1'b0, 100);
        drain("post_reset_t");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
